// File: rtl/key_event_decoder_pkg.sv
// Shared types and defaults for the keycode-to-player-control decoder.
package key_event_pkg;

  localparam int KEYS         = 8;
  localparam int NUM_SLOTS    = 2;
  localparam int NUM_PLAYERS  = 2;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 4;
  localparam int CNT_W        = 5;

  typedef logic [7:0]              usage_t;
  typedef usage_t [KEYS-1:0]       keymap_t;
  typedef logic [KEYS-1:0]         keyvec_t;

  // Usage ID 0x00 means "no key" in both the keycode word and the map.
  function automatic logic slot_hit(input usage_t slot, input usage_t entry);
    return (entry != '0) && (slot == entry);
  endfunction

endpackage

// File: rtl/key_event_decoder_key_match.sv
// Combinational lookup: which mapped keys are present in the registered keycode word.
// Every slot is compared against every map entry; duplicate entries each light their own bit.
module key_match
  import key_event_pkg::*;
#(
  parameter int NUM_SLOTS = key_event_pkg::NUM_SLOTS
) (
  input  logic [8*NUM_SLOTS-1:0] kc_i,
  input  keymap_t                map_i,
  output keyvec_t                live_o
);

  always_comb begin
    live_o = '0;
    for (int k = 0; k < KEYS; k++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (slot_hit(kc_i[8*s +: 8], map_i[k])) begin
          live_o[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Frame-aligned held/press vectors per player from the raw keycode word.
// Outputs and frame_tick update together 3 clk after a frame_clk rise; frozen in between.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int NUM_SLOTS    = key_event_pkg::NUM_SLOTS,
  parameter int REPEAT_DELAY = key_event_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE  = key_event_pkg::REPEAT_RATE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_clk,
  input  logic [8*NUM_SLOTS-1:0] keycode,
  input  logic [8*KEYS-1:0]      p1_controls,
  input  logic [8*KEYS-1:0]      p2_controls,
  output logic [KEYS-1:0]        p1_held,
  output logic [KEYS-1:0]        p2_held,
  output logic [KEYS-1:0]        p1_press,
  output logic [KEYS-1:0]        p2_press,
  output logic                   frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic                   fs1_q, fs2_q, fprev_q;
  logic                   tick;
  logic                   frame_tick_q;
  logic [8*NUM_SLOTS-1:0] kc_q;

  // Sync flops reset high: VS idles high, so coming out of reset never fakes a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs1_q        <= 1'b1;
      fs2_q        <= 1'b1;
      fprev_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      kc_q         <= '0;
    end else begin
      fs1_q        <= frame_clk;
      fs2_q        <= fs1_q;
      fprev_q      <= fs2_q;
      frame_tick_q <= tick;
      kc_q         <= keycode;
    end
  end

  assign tick       = fs2_q & ~fprev_q;
  assign frame_tick = frame_tick_q;

  genvar p;
  generate
    for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
      keymap_t          map;
      keyvec_t          live, live_prev_q, rise, rpt;
      keyvec_t          pending_q, pending_d;
      keyvec_t          held_q, held_d;
      keyvec_t          press_q, press_d;
      logic [CNT_W-1:0] cnt_q [KEYS];
      logic [CNT_W-1:0] cnt_d [KEYS];

      assign map = (p == 0) ? p1_controls : p2_controls;

      key_match #(.NUM_SLOTS(NUM_SLOTS)) u_match (
        .kc_i   (kc_q),
        .map_i  (map),
        .live_o (live)
      );

      assign rise = live & ~live_prev_q;

      // A rise in the tick cycle goes straight into press and is not left pending.
      always_comb begin
        rpt       = '0;
        held_d    = held_q;
        press_d   = press_q;
        pending_d = pending_q | rise;
        for (int k = 0; k < KEYS; k++) begin
          cnt_d[k] = cnt_q[k];
        end
        if (tick) begin
          for (int k = 0; k < KEYS; k++) begin
            if (!live[k]) begin
              cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
              rpt[k]   = 1'b1;
              cnt_d[k] = CNT_RELOAD;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end
          held_d    = live;
          press_d   = pending_q | rise | rpt;
          pending_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          live_prev_q <= '0;
          pending_q   <= '0;
          held_q      <= '0;
          press_q     <= '0;
          for (int k = 0; k < KEYS; k++) begin
            cnt_q[k] <= '0;
          end
        end else begin
          live_prev_q <= live;
          pending_q   <= pending_d;
          held_q      <= held_d;
          press_q     <= press_d;
          for (int k = 0; k < KEYS; k++) begin
            cnt_q[k] <= cnt_d[k];
          end
        end
      end
    end
  endgenerate

  assign p1_held  = g_player[0].held_q;
  assign p2_held  = g_player[1].held_q;
  assign p1_press = g_player[0].press_q;
  assign p2_press = g_player[1].press_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed and randomized checks of key_event_decoder against a frame-level reference model.
module tb_key_event_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_clk;
  logic [15:0] keycode;
  logic [63:0] p1_controls, p2_controls;
  logic [7:0]  p1_held, p2_held, p1_press, p2_press;
  logic        frame_tick;

  always #5 clk = ~clk;

  key_event_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .p1_controls (p1_controls),
    .p2_controls (p2_controls),
    .p1_held     (p1_held),
    .p2_held     (p2_held),
    .p1_press    (p1_press),
    .p2_press    (p2_press),
    .frame_tick  (frame_tick)
  );

  // Game map: P1 W S A D F G - -, P2 I K J L H E - -  (index 7 down to 0)
  localparam logic [63:0] MAP_P1 = 64'h1A_16_04_07_09_0A_00_00;
  localparam logic [63:0] MAP_P2 = 64'h0C_0E_0D_0F_0B_08_00_00;

  int checks   = 0;
  int failures = 0;

  // Reference model state: keycode words seen at the last two clock edges,
  // frame_clk seen at the last three, and per-player frame bookkeeping.
  logic [15:0] kp1, kp2;
  logic        f1, f2, f3;
  logic [7:0]  acc       [2];
  logic [7:0]  exp_held  [2];
  logic [7:0]  exp_press [2];
  int          nheld     [2][8];
  logic        exp_tick;

  function automatic logic [7:0] keys_in(input logic [15:0] kc, input logic [63:0] map);
    logic [7:0] r;
    logic [7:0] slot, ent;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 2; s++) begin
        slot = kc[8*s +: 8];
        ent  = map[8*i +: 8];
        if (slot != 8'h00 && slot == ent) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    kp1 = '0; kp2 = '0;
    f1 = 1'b1; f2 = 1'b1; f3 = 1'b1;
    exp_tick = 1'b0;
    for (int p = 0; p < 2; p++) begin
      acc[p] = '0; exp_held[p] = '0; exp_press[p] = '0;
      for (int k = 0; k < 8; k++) nheld[p][k] = 0;
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples at this edge, then compare.
  task automatic step();
    logic       report;
    logic [7:0] now, was, rpt;
    logic [63:0] map;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      report = f2 & ~f3;
      for (int p = 0; p < 2; p++) begin
        map = (p == 0) ? p1_controls : p2_controls;
        now = keys_in(kp1, map);
        was = keys_in(kp2, map);
        if (report) begin
          rpt = '0;
          for (int k = 0; k < 8; k++) begin
            nheld[p][k] = now[k] ? nheld[p][k] + 1 : 0;
            rpt[k] = (nheld[p][k] >= 20) && ((nheld[p][k] - 20) % 4 == 0);
          end
          exp_press[p] = acc[p] | (now & ~was) | rpt;
          exp_held[p]  = now;
          acc[p]       = '0;
        end else begin
          acc[p] = acc[p] | (now & ~was);
        end
      end
      exp_tick = report;
      kp2 = kp1; kp1 = keycode;
      f3 = f2; f2 = f1; f1 = frame_clk;
    end
    #1;
    check("frame_tick", {7'b0, frame_tick}, {7'b0, exp_tick});
    check("p1_held",  p1_held,  exp_held[0]);
    check("p2_held",  p2_held,  exp_held[1]);
    check("p1_press", p1_press, exp_press[0]);
    check("p2_press", p2_press, exp_press[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input int len);
    frame_clk = 1'b0;
    run(4);
    frame_clk = 1'b1;
    run(len - 4);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0, 1:    return 8'h00;
      2:       return 8'h1A;
      3:       return 8'h07;
      4:       return 8'h0C;
      5:       return 8'h16;
      6:       return 8'h0E;
      default: return 8'h04;
    endcase
  endfunction

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) keycode = {pick(), pick()};
      step();
    end
  endtask

  initial begin
    int tick_seen;
    logic [7:0] m8;
    reset = 1'b1; frame_clk = 1'b1; keycode = '0;
    p1_controls = MAP_P1; p2_controls = MAP_P2;
    model_reset();
    run(3);
    check("reset_p1_held", p1_held, 8'h00);
    check("reset_p1_press", p1_press, 8'h00);
    reset = 1'b0;
    run(5);

    // W held across three ticks
    keycode = 16'h1A00;
    frame(60);
    check("t1_p1_held", p1_held, 8'h80);
    check("t1_p1_press", p1_press, 8'h80);
    check("t1_p2_press", p2_press, 8'h00);
    frame(60);
    check("t1_f2_p1_press", p1_press, 8'h00);
    frame(60);
    check("t1_f3_p1_press", p1_press, 8'h00);
    check("t1_f3_p2_held", p2_held, 8'h00);
    keycode = '0;
    frame(60);

    // Tap of I inside one long frame
    frame_clk = 1'b0; run(4); frame_clk = 1'b1;
    run(20); keycode = 16'h0C00; run(1000); keycode = '0; run(20);
    frame(60);
    check("t2_p2_press", p2_press, 8'h80);
    check("t2_p2_held", p2_held, 8'h00);
    frame(60);
    check("t2_next_p2_press", p2_press, 8'h00);

    // W and I in different slots, one per player
    keycode = 16'h1A0C;
    frame(60);
    check("t3_p1_held", p1_held, 8'h80);
    check("t3_p2_held", p2_held, 8'h80);
    keycode = '0;
    frame(60);

    // D held for 30 frames: auto-repeat
    keycode = 16'h0007;
    for (int f = 1; f <= 30; f++) begin
      frame(60);
      check($sformatf("t4_press_f%0d", f), {7'b0, p1_press[4]},
            {7'b0, (f == 1 || f == 20 || f == 24 || f == 28)});
      check($sformatf("t4_held_f%0d", f), {7'b0, p1_held[4]}, 8'h01);
    end
    keycode = '0;
    frame(60);
    frame(60);

    // Key appears in exactly the tick cycle
    frame_clk = 1'b0; run(4);
    frame_clk = 1'b1; step();
    keycode = 16'h1A00; step();
    step();
    check("t5_tick", {7'b0, frame_tick}, 8'h01);
    check("t5_press_now", p1_press, 8'h80);
    run(50);
    frame(60);
    check("t5_press_next", p1_press, 8'h00);
    keycode = '0;
    frame(60);

    // Reset mid-frame with a pending press and frame_clk low
    frame_clk = 1'b0; run(3);
    keycode = 16'h1A00; run(5);
    keycode = '0; run(3);
    reset = 1'b1; run(2); reset = 1'b0;
    tick_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (frame_tick !== 1'b0) tick_seen++;
    end
    check("t6_no_tick", 8'(tick_seen), 8'h00);
    check("t6_p1_held", p1_held, 8'h00);
    frame_clk = 1'b1; run(56);
    check("t6_press_lost", p1_press, 8'h00);

    // Randomized: maps from a small pool (zeros, duplicates, shared keys), random keycode traffic
    for (int blk = 0; blk < 4; blk++) begin
      keycode = '0; run(3);
      for (int i = 0; i < 8; i++) begin
        m8 = pick(); p1_controls[8*i +: 8] = m8;
        m8 = pick(); p2_controls[8*i +: 8] = m8;
      end
      for (int f = 0; f < 15; f++) begin
        frame_clk = 1'b0; run_rand($urandom_range(1, 4));
        frame_clk = 1'b1; run_rand($urandom_range(6, 70));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
